// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: condition-mode encodings
// and 2-bit saturating counter states.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLTZ = 3'b011,
    BR_BGEZ = 3'b100,
    BR_BGTZ = 3'b101,
    BR_BLEZ = 3'b110,
    BR_RSVD = 3'b111
  } br_op_e;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // Saturating step of a 2-bit direction counter.
  function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && cnt != CNT_ST) begin
      res = cnt + 2'd1;
    end else if (!taken && cnt != CNT_SNT) begin
      res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port, one synchronous update port, every entry reset to CNT_INIT.
import branch_pkg::*;

module branch_bht #(
  parameter int         BHT_DEPTH = 16,
  parameter logic [1:0] CNT_INIT  = CNT_WNT,
  localparam int        IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] cnt_all [BHT_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_cnt
      logic [1:0] cnt_q;
      logic [1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (upd_en && upd_idx == IDX_W'(gi)) begin
          cnt_d = cnt_step(cnt_q, upd_taken);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= CNT_INIT;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_all[gi] = cnt_q;
    end
  endgenerate

  // Reads see the pre-update value when the same entry is written this cycle.
  assign rd_cnt = cnt_all[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution with BHT and registered redirect/flush to fetch.
// Optional saturating statistics counters when BRANCH_STATS_EN is defined.
import branch_pkg::*;

module branch_resolve_unit #(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter int         BHT_DEPTH = 16,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_taken,
  input  logic              br_valid,
  input  logic [2:0]        br_op,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [DATA_W-1:0] br_rs_val,
  input  logic [DATA_W-1:0] br_rt_val,
  input  logic [15:0]       br_imm,
  input  logic              br_pred_taken,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              taken_q
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic              redirect_valid_q, redirect_valid_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic              taken_d;
  logic              taken;
  logic              op_valid;
  logic              accept;
  logic              mispredict;
  logic              rs_neg;
  logic              rs_zero;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] fall_pc;
  logic [ADDR_W-1:0] target_pc;
  logic [1:0]        lookup_cnt;

  assign rs_neg  = br_rs_val[DATA_W-1];
  assign rs_zero = (br_rs_val == '0);

  always_comb begin
    taken = 1'b0;
    case (br_op_e'(br_op))
      BR_BEQ:  taken = (br_rs_val == br_rt_val);
      BR_BNE:  taken = (br_rs_val != br_rt_val);
      BR_BLTZ: taken = rs_neg;
      BR_BGEZ: taken = !rs_neg;
      BR_BGTZ: taken = !rs_neg && !rs_zero;
      BR_BLEZ: taken = rs_neg || rs_zero;
      default: taken = 1'b0;
    endcase
  end

  assign op_valid = (br_op != BR_NONE) && (br_op != BR_RSVD);
  // While a redirect is out, the EX instruction is wrong-path and is ignored.
  assign accept     = br_valid && op_valid && !redirect_valid_q;
  assign mispredict = accept && (taken != br_pred_taken);

  assign imm_ext   = {{(ADDR_W-16){br_imm[15]}}, br_imm};
  assign fall_pc   = br_pc + ADDR_W'(4);
  assign target_pc = fall_pc + (imm_ext << 2);

  always_comb begin
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    taken_d          = taken_q;
    if (accept) begin
      redirect_pc_d = taken ? target_pc : fall_pc;
      taken_d       = taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      taken_q          <= 1'b0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      taken_q          <= taken_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign flush          = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

  branch_bht #(
    .BHT_DEPTH (BHT_DEPTH),
    .CNT_INIT  (CNT_INIT)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (lookup_pc[IDX_W+1:2]),
    .rd_cnt    (lookup_cnt),
    .upd_en    (accept),
    .upd_idx   (br_pc[IDX_W+1:2]),
    .upd_taken (taken)
  );

  assign pred_taken = lookup_cnt[1];

  logic pc_bits_unused;
  assign pc_bits_unused = ^{lookup_pc[ADDR_W-1:IDX_W+2], lookup_pc[1:0], lookup_cnt[0]};

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (accept && stat_branches_q != 32'hFFFF_FFFF) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (mispredict && stat_mispredicts_q != 32'hFFFF_FFFF) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against a
// behavioural model of the branch rules and counter table.
import branch_pkg::*;

module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lookup_pc = '0;
  logic        pred_taken;
  logic        br_valid = 1'b0;
  logic [2:0]  br_op = '0;
  logic [31:0] br_pc = '0;
  logic [31:0] br_rs_val = '0;
  logic [31:0] br_rt_val = '0;
  logic [15:0] br_imm = '0;
  logic        br_pred_taken = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        taken_q;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_pc      (lookup_pc),
    .pred_taken     (pred_taken),
    .br_valid       (br_valid),
    .br_op          (br_op),
    .br_pc          (br_pc),
    .br_rs_val      (br_rs_val),
    .br_rt_val      (br_rt_val),
    .br_imm         (br_imm),
    .br_pred_taken  (br_pred_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .taken_q        (taken_q)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  // Reference model state
  int          m_bht [16];
  bit          m_rv;
  logic [31:0] m_rpc;
  bit          m_tq;
  longint      m_nbr;
  longint      m_nmp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_taken(input int op, input logic [31:0] rs, input logic [31:0] rt);
    int s;
    s = signed'(rs);
    case (op)
      1: return rs == rt;
      2: return rs != rt;
      3: return s < 0;
      4: return s >= 0;
      5: return s > 0;
      6: return s <= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_outputs();
    check_val("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    check_val("flush", 32'(flush), 32'(m_rv));
    check_val("redirect_pc", redirect_pc, m_rpc);
    check_val("taken_q", 32'(taken_q), 32'(m_tq));
`ifdef BRANCH_STATS_EN
    check_val("stat_branches", stat_branches, 32'(m_nbr));
    check_val("stat_mispredicts", stat_mispredicts, 32'(m_nmp));
`endif
  endtask

  task automatic do_reset(input int ncyc);
    rst      = 1'b1;
    br_valid = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_rv = 0; m_rpc = '0; m_tq = 0; m_nbr = 0; m_nmp = 0;
    check_outputs();
    rst = 1'b0;
    $display("txn %0d reset cycles=%0d rv=%0d rpc=%08h", txn, ncyc, redirect_valid, redirect_pc);
    txn++;
  endtask

  task automatic step(input bit v, input int op, input logic [31:0] pc, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [15:0] imm, input bit pt,
                      input logic [31:0] lk);
    bit t;
    bit acc;
    bit rv_next;
    int idx;
    br_valid = v; br_op = 3'(op); br_pc = pc; br_rs_val = rs; br_rt_val = rt;
    br_imm = imm; br_pred_taken = pt; lookup_pc = lk;
    #1;
    check_val("pred_taken", 32'(pred_taken), 32'(m_bht[lk[5:2]] >= 2));
    acc = v && op >= 1 && op <= 6 && !m_rv;
    rv_next = 0;
    if (acc) begin
      t    = ref_taken(op, rs, rt);
      idx  = int'(pc[5:2]);
      m_tq = t;
      m_rpc = t ? pc + 32'd4 + 32'(int'(shortint'(imm)) * 4) : pc + 32'd4;
      rv_next = (t != pt);
      if (t) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
      else   m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
      if (m_nbr < 64'hFFFF_FFFF) m_nbr++;
      if (rv_next && m_nmp < 64'hFFFF_FFFF) m_nmp++;
    end
    @(posedge clk);
    #1;
    m_rv = rv_next;
    check_outputs();
    $display("txn %0d v=%0d op=%0d pc=%08h pt=%0d -> rv=%0d rpc=%08h tq=%0d", txn, v, op, pc, pt,
             redirect_valid, redirect_pc, taken_q);
    txn++;
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] lk;

    do_reset(2);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 0, 16'h0, 0, 32'(i * 20));

    // BEQ mispredicted taken, then counter at index 0 predicts taken
    step(1, 1, 32'h100, 32'd5, 32'd5, 16'h0004, 0, 32'h100);
    step(0, 0, 32'h0, 0, 0, 16'h0, 0, 32'h100);

    // BNE correctly predicted not-taken, counter walks down to 00
    for (int i = 0; i < 3; i++) step(1, 2, 32'h104, 32'd7, 32'd7, 16'h0, 0, 32'h104);

    // Signed modes with rs = -1 and negative offset
    for (int op = 3; op <= 6; op++) begin
      step(1, op, 32'h200, 32'hFFFF_FFFF, 32'h0, 16'hFFFF, 0, 32'h200);
      step(0, 0, 32'h0, 0, 0, 16'h0, 0, 32'h200);
    end

    // Squash: the branch right after a mispredict must not touch its entry
    step(1, 1, 32'h300, 32'd1, 32'd1, 16'h0, 0, 32'h308);
    step(1, 1, 32'h308, 32'd2, 32'd2, 16'h0, 0, 32'h308);
    step(0, 0, 32'h0, 0, 0, 16'h0, 0, 32'h308);

    // Saturation at 11, same-cycle lookup sees pre-update value
    for (int i = 0; i < 4; i++) step(1, 1, 32'h10C, 32'd3, 32'd3, 16'h0, 1, 32'h10C);
    step(0, 0, 32'h0, 0, 0, 16'h0, 0, 32'h10C);

    // Target wrap-around
    step(1, 1, 32'hFFFF_FFFC, 32'd0, 32'd0, 16'h0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 16'h0, 0, 32'h0);

    // Reset during a redirect cycle drops it
    step(1, 4, 32'h400, 32'd9, 32'd0, 16'h0010, 0, 32'h0);
    do_reset(1);

    for (int n = 0; n < 400; n++) begin
      pc = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                       : 32'h1000 + 32'($urandom_range(0, 15) << 2);
      case ($urandom_range(0, 3))
        0: rs = 32'h0;
        1: rs = 32'hFFFF_FFFF;
        default: rs = $urandom;
      endcase
      rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
      lk = ($urandom_range(0, 1) == 1) ? pc : 32'h1000 + 32'($urandom_range(0, 15) << 2);
      step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), pc, rs, rt,
           16'($urandom), bit'($urandom_range(0, 1)), lk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
